// File: rtl/eth_rx_filter_pkg.sv
// Shared types and constants for the RX destination-MAC filter.
package eth_rx_filter_pkg;
  typedef enum logic [1:0] {HDR, DRAIN, PASS, DROP} state_t;
  localparam int          ETH_ALEN  = 6;
  localparam logic [47:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;
endpackage

// File: rtl/eth_rx_filter_stats.sv
// Saturating pass/drop/runt frame counters for the RX destination-MAC filter.
module eth_rx_filter_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        pass_inc,
  input  logic        drop_inc,
  input  logic        runt_inc,
  output logic [31:0] stat_pass,
  output logic [31:0] stat_drop,
  output logic [31:0] stat_runt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pass <= '0;
      stat_drop <= '0;
      stat_runt <= '0;
    end else begin
      if (pass_inc) stat_pass <= sat_inc(stat_pass);
      if (drop_inc) stat_drop <= sat_inc(stat_drop);
      if (runt_inc) stat_runt <= sat_inc(stat_runt);
    end
  end

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter on the 8-bit RX AXI-Stream: buffers the DA, then forwards or drops the frame.
// Define ETH_RX_FILTER_STATS_EN to add the stat_pass/stat_drop/stat_runt counter outputs.
module eth_rx_mac_filter
  import eth_rx_filter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] local_mac,
  input  logic        promisc,
  input  logic        accept_mcast,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
`ifdef ETH_RX_FILTER_STATS_EN
  ,
  output logic [31:0] stat_pass,
  output logic [31:0] stat_drop,
  output logic [31:0] stat_runt
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(ETH_ALEN - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [7:0]  da_p0 [ETH_ALEN];
  logic [47:0] mac_p0;
  logic        promisc_p0;
  logic        mcast_p0;
  logic        s_hs;
  logic [47:0] da_cat;
  logic        hit;
  logic        hdr_done;
  logic        runt;

  function automatic logic da_match(input logic [47:0] da, input logic [47:0] mac,
                                    input logic prom, input logic mc);
    return prom | (da == mac) | (da == ETH_BCAST) | (mc & da[40]);
  endfunction

  assign s_hs     = s_axis_tvalid & s_axis_tready;
  // The sixth DA byte is compared straight off the bus so the decision lands on its accept edge.
  assign da_cat   = {da_p0[0], da_p0[1], da_p0[2], da_p0[3], da_p0[4], s_axis_tdata};
  assign hit      = da_match(da_cat, mac_p0, promisc_p0, mcast_p0);
  assign hdr_done = (state == HDR) & s_hs & ~s_axis_tlast & (cnt == LAST_IDX);
  assign runt     = (state == HDR) & s_hs & s_axis_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HDR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Header capture stage: DA bytes and per-frame config snapshot
  always_ff @(posedge clk) begin
    if (state == HDR && s_hs) begin
      da_p0[cnt] <= s_axis_tdata;
      if (cnt == 3'd0) begin
        mac_p0     <= local_mac;
        promisc_p0 <= promisc;
        mcast_p0   <= accept_mcast;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      HDR: begin
        if (s_hs) begin
          if (s_axis_tlast) begin
            cnt_nxt = '0;
          end else if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = hit ? DRAIN : DROP;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      DRAIN: begin
        if (m_axis_tready) begin
          if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = PASS;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      PASS, DROP: begin
        if (s_hs && s_axis_tlast) begin
          cnt_nxt   = '0;
          state_nxt = HDR;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = HDR;
      end
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state)
      DRAIN: begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = da_p0[cnt];
      end
      PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
      end
      default: ;
    endcase
  end

`ifdef ETH_RX_FILTER_STATS_EN
  eth_rx_filter_stats u_stats (
    .clk       (clk),
    .rst       (rst),
    .pass_inc  (hdr_done & hit),
    .drop_inc  (hdr_done & ~hit),
    .runt_inc  (runt),
    .stat_pass (stat_pass),
    .stat_drop (stat_drop),
    .stat_runt (stat_runt)
  );
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed bench for eth_rx_mac_filter with an expected-beat scoreboard.
module tb_eth_rx_mac_filter;
  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] local_mac;
  logic        promisc;
  logic        accept_mcast;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic        s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
`ifdef ETH_RX_FILTER_STATS_EN
  logic [31:0] stat_pass, stat_drop, stat_runt;
`endif

  always #5 clk = ~clk;

  eth_rx_mac_filter dut (
    .clk           (clk),
    .rst           (rst),
    .local_mac     (local_mac),
    .promisc       (promisc),
    .accept_mcast  (accept_mcast),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser)
`ifdef ETH_RX_FILTER_STATS_EN
    ,
    .stat_pass     (stat_pass),
    .stat_drop     (stat_drop),
    .stat_runt     (stat_runt)
`endif
  );

  logic [9:0]  exp_q [$];
  logic [7:0]  frm [$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_rdy = 0;
  bit          quiet = 0;
  int          exp_pass = 0, exp_drop = 0, exp_runt = 0;
  logic [9:0]  prev_beat;
  bit          prev_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic build(input logic [47:0] da, input int len, input int seed);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47 - 8*i -: 8]);
    for (int i = 6; i < len; i++) frm.push_back(8'(i * 7 + seed));
  endtask

  task automatic push_exp(input int n, input logic user);
    for (int i = 0; i < n; i++) begin
      logic last;
      last = (i == frm.size() - 1);
      exp_q.push_back({frm[i], last, last & user});
    end
  endtask

  task automatic send(input int from, input int upto, input logic user, output int first_wait);
    first_wait = 0;
    for (int i = from; i < upto; i++) begin
      bit hs;
      int w;
      s_tdata  = frm[i];
      s_tlast  = (i == frm.size() - 1);
      s_tuser  = s_tlast & user;
      s_tvalid = 1'b1;
      w = 0;
      hs = 0;
      while (!hs && w < 2000) begin
        @(negedge clk);
        hs = s_tready;
        @(posedge clk);
        #1;
        w++;
      end
      if (i == from) first_wait = w;
      if (!hs) chk("s_handshake_timeout", 64'(hs), 64'd1);
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_stats();
`ifdef ETH_RX_FILTER_STATS_EN
    chk("stat_pass", 64'(stat_pass), 64'(exp_pass));
    chk("stat_drop", 64'(stat_drop), 64'(exp_drop));
    chk("stat_runt", 64'(stat_runt), 64'(exp_runt));
`endif
  endtask

  always @(posedge clk) begin
    #1;
    m_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(negedge clk) begin
    logic [9:0] got;
    got = {m_tdata, m_tlast, m_tuser};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_stable", {53'd0, m_tvalid, got}, {53'd0, 1'b1, prev_beat});
      if (quiet) chk("no_tvalid_on_drop", 64'(m_tvalid), 64'd0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_beat: observed %0h expected none", got);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("out_beat", 64'(got), 64'(e));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = got;
    end
  end

  initial begin
    int fw;
    rst          = 1'b1;
    local_mac    = 48'h02_00_00_00_00_01;
    promisc      = 1'b0;
    accept_mcast = 1'b0;
    m_tready     = 1'b1;
    idle();
    s_tdata      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tuser", 64'(m_tuser), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_stats();

    // 1: unicast match, 64 bytes, first output one cycle after the sixth byte
    build(48'h02_00_00_00_00_01, 64, 1);
    push_exp(64, 1'b0);
    send(0, 6, 1'b0, fw);
    @(negedge clk);
    chk("latency_tvalid", 64'(m_tvalid), 64'd1);
    chk("latency_tdata", 64'(m_tdata), 64'(frm[0]));
    send(6, 64, 1'b0, fw);
    idle();
    exp_pass++;
    wait_drain();

    // 2: foreign unicast dropped, matching frame back-to-back with no bubble
    build(48'h02_00_00_00_00_99, 60, 2);
    quiet = 1;
    send(0, 60, 1'b0, fw);
    quiet = 0;
    exp_drop++;
    build(48'h02_00_00_00_00_01, 60, 3);
    push_exp(60, 1'b0);
    send(0, 60, 1'b0, fw);
    chk("b2b_first_byte_wait", 64'(fw), 64'd1);
    idle();
    exp_pass++;
    wait_drain();

    // 3: broadcast passes; multicast dropped then accepted; config flip mid-frame ignored
    build(48'hFF_FF_FF_FF_FF_FF, 60, 4);
    push_exp(60, 1'b0);
    send(0, 60, 1'b0, fw);
    idle();
    exp_pass++;
    wait_drain();
    build(48'h01_00_5E_00_00_01, 60, 5);
    quiet = 1;
    send(0, 2, 1'b0, fw);
    accept_mcast = 1'b1;
    promisc      = 1'b1;
    send(2, 60, 1'b0, fw);
    quiet = 0;
    idle();
    exp_drop++;
    promisc = 1'b0;
    build(48'h01_00_5E_00_00_01, 60, 6);
    push_exp(60, 1'b0);
    send(0, 60, 1'b0, fw);
    idle();
    exp_pass++;
    wait_drain();
    accept_mcast = 1'b0;

    // 4: runts (4 bytes, then tlast on the sixth byte) discarded, next frame passes
    build(48'h02_00_00_00_00_01, 4, 7);
    quiet = 1;
    send(0, 4, 1'b0, fw);
    exp_runt++;
    chk_stats();
    build(48'h02_00_00_00_00_01, 6, 8);
    send(0, 6, 1'b0, fw);
    quiet = 0;
    exp_runt++;
    build(48'h02_00_00_00_00_01, 60, 9);
    push_exp(60, 1'b0);
    send(0, 60, 1'b0, fw);
    idle();
    exp_pass++;
    wait_drain();
    chk_stats();

    // 5: tuser on last byte with random backpressure
    rand_rdy = 1;
    build(48'h02_00_00_00_00_01, 64, 10);
    push_exp(64, 1'b1);
    send(0, 64, 1'b1, fw);
    idle();
    exp_pass++;
    wait_drain();
    rand_rdy = 0;
    repeat (2) @(posedge clk);
    #1;

    // 6: reset in PASS after 20 bytes, then a fresh filtering decision
    build(48'h02_00_00_00_00_01, 60, 11);
    push_exp(20, 1'b0);
    send(0, 20, 1'b0, fw);
    s_tdata = frm[20];
    rst = 1'b1;
    exp_pass = 0;
    exp_drop = 0;
    exp_runt = 0;
    @(negedge clk);
    chk("rst_mid_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mid_s_tready", 64'(s_tready), 64'd1);
    chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    chk_stats();
    build(48'h02_00_00_00_00_42, 40, 12);
    quiet = 1;
    send(0, 40, 1'b0, fw);
    quiet = 0;
    exp_drop++;
    build(48'h02_00_00_00_00_01, 40, 13);
    push_exp(40, 1'b0);
    send(0, 40, 1'b0, fw);
    idle();
    exp_pass++;
    wait_drain();
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
